pdm_cic_decimator: RTL and testbench

Front-end stage of the PDM-microphone → FFT → Ethernet path. Generates the microphone bit clock, captures the 1-bit PDM stream, and decimates it by 64 through a 4th-order CIC filter. Emits signed 16-bit PCM samples at ~39 kHz over a valid/ready handshake to the FFT input buffer. The block sits directly behind the `M_CLK`/`M_DATA`/`M_LRSEL` board pins, inside `ethernet_top`.

---
 rtl/pdm_pkg.sv | 27 ++
 rtl/pdm_clk_gen.sv | 38 +++
 rtl/pdm_cic_decimator.sv | 232 +++++++++++++++++++++++
 tb/tb_pdm_cic_decimator.sv | 371 +++++++++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/pdm_pkg.sv
// Shared types and constants for the PDM microphone CIC decimator.
package pdm_pkg;

  localparam int unsigned CIC_ORDER = 4;
  localparam int unsigned DECIM_DEFAULT = 64;

  // Accumulator width needed for wrap-safe CIC arithmetic: 1-bit signed input
  // (2 bits) plus order * log2(decimation) bits of growth.
  function automatic int unsigned cic_acc_w(input int unsigned decim);
    return 2 + CIC_ORDER * $clog2(decim);
  endfunction

  localparam int unsigned ACC_W = cic_acc_w(DECIM_DEFAULT);

  typedef logic signed [ACC_W-1:0] cic_acc_t;
  typedef logic signed [15:0]      pcm_sample_t;

  // Comb sequencer: one comb stage evaluated per clock after each decimation tick.
  typedef enum logic [2:0] {
    StIdle,
    StC1,
    StC2,
    StC3,
    StC4
  } cic_state_t;

endpackage

// File: rtl/pdm_clk_gen.sv
// PDM bit-clock generator: divides the system clock down to m_clk and flags
// the last system cycle of each m_clk high phase (the capture point).
module pdm_clk_gen
  import pdm_pkg::*;
#(
  parameter int unsigned CLK_DIV = 20
) (
  input  logic i_clk,
  input  logic i_rst,
  output logic o_m_clk,
  output logic o_bit_tick
);

  localparam int unsigned CntW = (CLK_DIV > 1) ? $clog2(CLK_DIV) : 1;

  logic [CntW-1:0] r_cnt;
  logic            r_m_clk;
  logic            w_wrap;

  assign w_wrap = (r_cnt == CntW'(CLK_DIV - 1));

  // Half-period counter; m_clk toggles each time it wraps.
  always_ff @(posedge i_clk) begin
    if (i_rst) begin
      r_cnt   <= '0;
      r_m_clk <= 1'b0;
    end else if (w_wrap) begin
      r_cnt   <= '0;
      r_m_clk <= ~r_m_clk;
    end else begin
      r_cnt <= r_cnt + CntW'(1);
    end
  end

  assign o_m_clk    = r_m_clk;
  assign o_bit_tick = r_m_clk & w_wrap;

endmodule

// File: rtl/pdm_cic_decimator.sv
// PDM front end: bit clock, 2-FF capture, 4th-order CIC decimator, scaling,
// saturation and a valid/ready output register with sticky overrun.
// Optional DC-removal high-pass enabled by defining PDM_DC_BLOCK_EN.
module pdm_cic_decimator
  import pdm_pkg::*;
#(
  parameter int unsigned CLK_DIV = 20,
  parameter int unsigned DECIM   = 64,
  parameter int unsigned OUT_W   = 16
) (
  input  logic                    clk,
  input  logic                    rst,
  output logic                    m_clk,
  input  logic                    m_data,
  output logic                    m_lrsel,
  output logic signed [OUT_W-1:0] pcm_data,
  output logic                    pcm_valid,
  input  logic                    pcm_ready,
  output logic                    overrun
);

  localparam int unsigned AccW   = cic_acc_w(DECIM);
  localparam int unsigned PhW    = $clog2(DECIM);
  localparam int unsigned Shift  = AccW - OUT_W - 1;
  localparam int          SatMax = (1 << (OUT_W - 1)) - 1;
  localparam int          SatMin = -SatMax - 1;

  logic w_bit_tick;
  logic w_dec_tick;

  pdm_clk_gen #(
    .CLK_DIV (CLK_DIV)
  ) u_clk_gen (
    .i_clk      (clk),
    .i_rst      (rst),
    .o_m_clk    (m_clk),
    .o_bit_tick (w_bit_tick)
  );

  assign m_lrsel = 1'b0;

  logic r_sync1, r_sync2;

  // Two-flop synchronizer for the asynchronous microphone data.
  always_ff @(posedge clk) begin
    if (rst) begin
      r_sync1 <= 1'b0;
      r_sync2 <= 1'b0;
    end else begin
      r_sync1 <= m_data;
      r_sync2 <= r_sync1;
    end
  end

  logic signed [AccW-1:0] w_x, w_i1, w_i2, w_i3, w_i4;
  logic signed [AccW-1:0] r_i1, r_i2, r_i3, r_i4;
  logic [PhW-1:0]         r_phase;

  // PDM bit maps to +1 / -1; integrators form an unpipelined cascade so the
  // latched value already includes the current bit.
  assign w_x  = r_sync2 ? {{(AccW-1){1'b0}}, 1'b1} : {AccW{1'b1}};
  assign w_i1 = r_i1 + w_x;
  assign w_i2 = r_i2 + w_i1;
  assign w_i3 = r_i3 + w_i2;
  assign w_i4 = r_i4 + w_i3;

  assign w_dec_tick = w_bit_tick && (r_phase == PhW'(DECIM - 1));

  // Integrators and decimation phase advance once per PDM bit; wrap is intended.
  always_ff @(posedge clk) begin
    if (rst) begin
      r_i1    <= '0;
      r_i2    <= '0;
      r_i3    <= '0;
      r_i4    <= '0;
      r_phase <= '0;
    end else if (w_bit_tick) begin
      r_i1    <= w_i1;
      r_i2    <= w_i2;
      r_i3    <= w_i3;
      r_i4    <= w_i4;
      r_phase <= r_phase + PhW'(1);
    end
  end

  cic_state_t r_state, w_state_next;

  // Comb sequencer state register.
  always_ff @(posedge clk) begin
    if (rst) r_state <= StIdle;
    else     r_state <= w_state_next;
  end

  // Comb sequencer next state: start on dec_tick, then one stage per cycle.
  always_comb begin
    w_state_next = r_state;
    unique case (r_state)
      StIdle:  if (w_dec_tick) w_state_next = StC1;
      StC1:    w_state_next = StC2;
      StC2:    w_state_next = StC3;
      StC3:    w_state_next = StC4;
      StC4:    w_state_next = StIdle;
      default: w_state_next = StIdle;
    endcase
  end

  logic signed [AccW-1:0] r_dec, r_c, r_d1, r_d2, r_d3, r_d4;
  logic signed [AccW-1:0] w_cin, w_cdel, w_cout, w_shift;
  logic signed [OUT_W-1:0] w_sat;

  // Select the active comb stage's input and delay element.
  always_comb begin
    w_cin  = r_c;
    w_cdel = r_d1;
    unique case (r_state)
      StC1:    begin w_cin = r_dec; w_cdel = r_d1; end
      StC2:    w_cdel = r_d2;
      StC3:    w_cdel = r_d3;
      StC4:    w_cdel = r_d4;
      default: w_cdel = r_d1;
    endcase
  end

  assign w_cout  = w_cin - w_cdel;
  assign w_shift = w_cout >>> Shift;

  // Scale down and clamp to the PCM range.
  always_comb begin
    if (w_shift > AccW'(SatMax))      w_sat = OUT_W'(SatMax);
    else if (w_shift < AccW'(SatMin)) w_sat = OUT_W'(SatMin);
    else                              w_sat = w_shift[OUT_W-1:0];
  end

  // Decimated sample latch and comb delay line.
  always_ff @(posedge clk) begin
    if (rst) begin
      r_dec <= '0;
      r_c   <= '0;
      r_d1  <= '0;
      r_d2  <= '0;
      r_d3  <= '0;
      r_d4  <= '0;
    end else begin
      if (w_dec_tick) r_dec <= w_i4;
      case (r_state)
        StC1:    begin r_d1 <= w_cin; r_c <= w_cout; end
        StC2:    begin r_d2 <= w_cin; r_c <= w_cout; end
        StC3:    begin r_d3 <= w_cin; r_c <= w_cout; end
        StC4:    r_d4 <= w_cin;
        default: ;
      endcase
    end
  end

  logic                    w_load;
  logic signed [OUT_W-1:0] w_load_data;

`ifdef PDM_DC_BLOCK_EN
  localparam int unsigned DcW   = OUT_W + 2;
  localparam int          DcMax = (1 << (DcW - 1)) - 1;
  localparam int          DcMin = -DcMax - 1;

  logic                    r_dc_go;
  logic signed [OUT_W-1:0] r_dc_in, r_dc_xp;
  logic signed [DcW-1:0]   r_dc_yp, w_dc_y;
  logic signed [DcW:0]     w_dc_sum;
  logic signed [OUT_W-1:0] w_dc_out;

  assign w_dc_sum = (DcW+1)'(r_dc_in) - (DcW+1)'(r_dc_xp) + (DcW+1)'(r_dc_yp)
                  - (DcW+1)'(r_dc_yp >>> 8);

  // y[n] = x[n] - x[n-1] + y[n-1] - y[n-1]/256, clamped internally and on output.
  always_comb begin
    if (w_dc_sum > (DcW+1)'(DcMax))      w_dc_y = DcW'(DcMax);
    else if (w_dc_sum < (DcW+1)'(DcMin)) w_dc_y = DcW'(DcMin);
    else                                 w_dc_y = w_dc_sum[DcW-1:0];
    if (w_dc_y > DcW'(SatMax))           w_dc_out = OUT_W'(SatMax);
    else if (w_dc_y < DcW'(SatMin))      w_dc_out = OUT_W'(SatMin);
    else                                 w_dc_out = w_dc_y[OUT_W-1:0];
  end

  // DC-block state: stage the CIC result in C4, filter it the following cycle.
  always_ff @(posedge clk) begin
    if (rst) begin
      r_dc_go <= 1'b0;
      r_dc_in <= '0;
      r_dc_xp <= '0;
      r_dc_yp <= '0;
    end else begin
      r_dc_go <= (r_state == StC4);
      if (r_state == StC4) r_dc_in <= w_sat;
      if (r_dc_go) begin
        r_dc_xp <= r_dc_in;
        r_dc_yp <= w_dc_y;
      end
    end
  end

  assign w_load      = r_dc_go;
  assign w_load_data = w_dc_out;
`else
  assign w_load      = (r_state == StC4);
  assign w_load_data = w_sat;
`endif

  logic                    r_valid, r_overrun;
  logic signed [OUT_W-1:0] r_data;

  // Output register: hold until accepted; a new sample arriving while the
  // held one is unaccepted is dropped and flagged.
  always_ff @(posedge clk) begin
    if (rst) begin
      r_valid   <= 1'b0;
      r_data    <= '0;
      r_overrun <= 1'b0;
    end else if (w_load) begin
      if (!r_valid || pcm_ready) begin
        r_data  <= w_load_data;
        r_valid <= 1'b1;
      end else begin
        r_overrun <= 1'b1;
      end
    end else if (r_valid && pcm_ready) begin
      r_valid <= 1'b0;
    end
  end

  assign pcm_data  = r_data;
  assign pcm_valid = r_valid;
  assign overrun   = r_overrun;

endmodule

// File: tb/tb_pdm_cic_decimator.sv
// Self-checking bench for pdm_cic_decimator: a stimulus driver feeds one bit
// per m_clk period and a reference model computes each decimated sample as a
// direct FIR (four cascaded length-DECIM boxcars) over the recorded bits.
module tb_pdm_cic_decimator;

  localparam int CLK_DIV = 20;
  localparam int DECIM   = 64;
  localparam int OUT_W   = 16;
  localparam int NTAPS   = 4 * (DECIM - 1) + 1;
  localparam int PERIOD  = 2 * CLK_DIV * DECIM;
  localparam int SHIFT   = (2 + 4 * $clog2(DECIM)) - OUT_W - 1;
  localparam int PMAX    = (1 << (OUT_W - 1)) - 1;
  localparam int PMIN    = -PMAX - 1;

  logic                    clk = 1'b0;
  logic                    rst;
  logic                    m_clk;
  logic                    m_data;
  logic                    m_lrsel;
  logic signed [OUT_W-1:0] pcm_data;
  logic                    pcm_valid;
  logic                    pcm_ready;
  logic                    overrun;

  pdm_cic_decimator #(
    .CLK_DIV (CLK_DIV),
    .DECIM   (DECIM),
    .OUT_W   (OUT_W)
  ) dut (
    .clk       (clk),
    .rst       (rst),
    .m_clk     (m_clk),
    .m_data    (m_data),
    .m_lrsel   (m_lrsel),
    .pcm_data  (pcm_data),
    .pcm_valid (pcm_valid),
    .pcm_ready (pcm_ready),
    .overrun   (overrun)
  );

  always #5 clk = ~clk;

  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  int checks = 0;
  int errors = 0;

  // Stimulus: 0 const0, 1 const1, 2 alternating, 3 lfsr bit 0, 4 random density
  int         mode    = 0;
  int         density = 50;
  logic [7:0] lfsr    = 8'h01;
  bit         x[$];
  longint     h[0:255];

  // One new PDM bit just after each m_clk rising edge, recorded for the model.
  initial begin
    bit b;
    forever begin
      @(posedge m_clk);
      #1;
      case (mode)
        0: b = 1'b0;
        1: b = 1'b1;
        2: b = (x.size() % 2 == 0);
        3: begin
          b    = lfsr[0];
          lfsr = {lfsr[6:0], lfsr[7] ^ lfsr[5] ^ lfsr[4] ^ lfsr[3]};
        end
        default: b = ($urandom_range(0, 99) < density);
      endcase
      m_data = b;
      x.push_back(b);
    end
  end

  // CIC impulse response: four cascaded boxcars of length DECIM.
  task automatic build_taps();
    longint tmp[0:255];
    for (int i = 0; i < 256; i++) h[i] = 0;
    h[0] = 1;
    repeat (4) begin
      for (int i = 0; i < 256; i++) begin
        longint s = 0;
        for (int t = 0; t < DECIM; t++) if (i - t >= 0) s += h[i - t];
        tmp[i] = s;
      end
      for (int i = 0; i < 256; i++) h[i] = tmp[i];
    end
  endtask

  // Expected k-th sample (k from 1) after reset; bits before reset count as 0.
  function automatic int model(input int k);
    longint acc = 0;
    for (int j = 0; j < NTAPS; j++) begin
      int idx = DECIM * k - 1 - j;
      if (idx >= 0 && idx < x.size()) acc += h[j] * (x[idx] ? 64'sd1 : -64'sd1);
    end
    acc = acc >>> SHIFT;
    if (acc > PMAX) return PMAX;
    if (acc < PMIN) return PMIN;
    return int'(acc);
  endfunction

  task automatic do_reset();
    @(posedge clk);
    #1 rst = 1'b1;
    repeat (2) @(posedge clk);
    #1;
    x.delete();
    rst = 1'b0;
  endtask

  // Wait (bounded) for a handshake-accepted sample.
  task automatic wait_sample(input int budget, output logic found, output int d, output int t);
    found = 1'b0;
    d     = 0;
    t     = 0;
    for (int i = 0; i < budget; i++) begin
      @(posedge clk);
      #1;
      if (pcm_valid && pcm_ready) begin
        found = 1'b1;
        d     = int'(pcm_data);
        t     = cyc;
        break;
      end
    end
  endtask

  task automatic test_reset();
    int n;
    pcm_ready = 1'b1;
    mode      = 0;
    do_reset();
    checks++; if (m_clk !== 1'b0)     begin errors++; $display("FAIL reset_m_clk: got %b expected 0", m_clk); end
    checks++; if (m_lrsel !== 1'b0)   begin errors++; $display("FAIL reset_m_lrsel: got %b expected 0", m_lrsel); end
    checks++; if (pcm_valid !== 1'b0) begin errors++; $display("FAIL reset_pcm_valid: got %b expected 0", pcm_valid); end
    checks++; if (pcm_data !== '0)    begin errors++; $display("FAIL reset_pcm_data: got %0d expected 0", pcm_data); end
    checks++; if (overrun !== 1'b0)   begin errors++; $display("FAIL reset_overrun: got %b expected 0", overrun); end
    n = 0;
    for (int i = 1; i <= 4 * CLK_DIV; i++) begin
      @(posedge clk);
      #1;
      if (m_clk === 1'b1) begin n = i; break; end
    end
    checks++;
    if (n != CLK_DIV) begin
      errors++; $display("FAIL first_m_clk_rise: got cycle %0d expected %0d", n, CLK_DIV);
    end
  endtask

  task automatic test_const(input bit v);
    logic found;
    int   d, t, settled;
    pcm_ready = 1'b1;
    mode      = v ? 1 : 0;
    settled   = v ? PMAX : PMIN;
    do_reset();
    for (int k = 1; k <= 5; k++) begin
      wait_sample(PERIOD + 200, found, d, t);
      checks++;
      if (!found) begin
        errors++; $display("FAIL const%0d_timeout: sample %0d missing", v, k);
        return;
      end
      checks++;
      if (d != model(k)) begin
        errors++; $display("FAIL const%0d_model k=%0d: got %0d expected %0d", v, k, d, model(k));
      end
    end
    checks++;
    if (d != settled) begin
      errors++; $display("FAIL const%0d_settled: got %0d expected %0d", v, d, settled);
    end
    checks++;
    if (overrun !== 1'b0) begin
      errors++; $display("FAIL const%0d_overrun: got %b expected 0", v, overrun);
    end
  endtask

  task automatic test_alternate();
    logic found;
    int   d, t, t_prev;
    pcm_ready = 1'b1;
    mode      = 2;
    do_reset();
    t_prev = 0;
    for (int k = 1; k <= 5; k++) begin
      wait_sample(PERIOD + 200, found, d, t);
      checks++;
      if (!found) begin
        errors++; $display("FAIL alt_timeout: sample %0d missing", k);
        return;
      end
      checks++;
      if (d != model(k)) begin
        errors++; $display("FAIL alt_model k=%0d: got %0d expected %0d", k, d, model(k));
      end
      if (k > 1) begin
        checks++;
        if (t - t_prev != PERIOD) begin
          errors++; $display("FAIL alt_spacing k=%0d: got %0d expected %0d", k, t - t_prev, PERIOD);
        end
      end
      t_prev = t;
    end
    checks++;
    if (d > 1 || d < -1) begin
      errors++; $display("FAIL alt_settled: got %0d expected 0 +/- 1", d);
    end
  endtask

  task automatic test_stream(input int m);
    logic found;
    int   d, t;
    pcm_ready = 1'b1;
    mode      = m;
    lfsr      = 8'($urandom_range(1, 255));
    do_reset();
    for (int k = 1; k <= 4; k++) begin
      density = $urandom_range(5, 95);
      wait_sample(PERIOD + 200, found, d, t);
      checks++;
      if (!found) begin
        errors++; $display("FAIL stream%0d_timeout: sample %0d missing", m, k);
        return;
      end
      checks++;
      if (d != model(k)) begin
        errors++; $display("FAIL stream%0d_model k=%0d: got %0d expected %0d", m, k, d, model(k));
      end
    end
    checks++;
    if (overrun !== 1'b0) begin
      errors++; $display("FAIL stream%0d_overrun: got %b expected 0", m, overrun);
    end
  endtask

  task automatic test_overrun();
    logic found;
    int   d1, d, t, start;
    logic bad;
    pcm_ready = 1'b0;
    mode      = 4;
    density   = 70;
    do_reset();
    found = 1'b0;
    d1    = 0;
    start = cyc;
    for (int i = 0; i < PERIOD + 200; i++) begin
      @(posedge clk);
      #1;
      if (pcm_valid) begin found = 1'b1; d1 = int'(pcm_data); start = cyc; break; end
    end
    checks++;
    if (!found) begin
      errors++; $display("FAIL ovr_first_timeout: no sample");
      return;
    end
    checks++;
    if (d1 != model(1)) begin
      errors++; $display("FAIL ovr_first_model: got %0d expected %0d", d1, model(1));
    end
    checks++;
    if (overrun !== 1'b0) begin
      errors++; $display("FAIL ovr_early: got %b expected 0", overrun);
    end
    bad = 1'b0;
    while (cyc - start < 3000) begin
      @(posedge clk);
      #1;
      if (pcm_valid !== 1'b1 || int'(pcm_data) != d1) bad = 1'b1;
    end
    checks++;
    if (bad) begin
      errors++; $display("FAIL ovr_hold: got data %0d valid %b expected %0d held", pcm_data, pcm_valid, d1);
    end
    checks++;
    if (overrun !== 1'b1) begin
      errors++; $display("FAIL ovr_flag: got %b expected 1", overrun);
    end
    pcm_ready = 1'b1;
    @(posedge clk);
    #1;
    checks++;
    if (pcm_valid !== 1'b0) begin
      errors++; $display("FAIL ovr_valid_drop: got %b expected 0", pcm_valid);
    end
    wait_sample(2 * PERIOD, found, d, t);
    checks++;
    if (!found) begin
      errors++; $display("FAIL ovr_third_timeout: no sample");
    end else begin
      checks++;
      if (d != model(3)) begin
        errors++; $display("FAIL ovr_third_model: got %0d expected %0d", d, model(3));
      end
    end
    checks++;
    if (overrun !== 1'b1) begin
      errors++; $display("FAIL ovr_sticky: got %b expected 1", overrun);
    end
    do_reset();
    checks++;
    if (overrun !== 1'b0) begin
      errors++; $display("FAIL ovr_clear: got %b expected 0", overrun);
    end
  endtask

  task automatic test_reset_mid_comb();
    logic bad;
    int   at;
    pcm_ready = 1'b1;
    mode      = 4;
    density   = 60;
    do_reset();
    bad = 1'b0;
    // dec_tick is high in the cycle ending at edge PERIOD; reset two cycles later.
    for (int n = 1; n <= PERIOD + 2; n++) begin
      @(posedge clk);
      #1;
      if (pcm_valid) bad = 1'b1;
    end
    checks++;
    if (bad) begin
      errors++; $display("FAIL mid_early_valid: got 1 expected 0");
    end
    rst = 1'b1;
    @(posedge clk);
    #1;
    checks++; if (pcm_valid !== 1'b0) begin errors++; $display("FAIL mid_pcm_valid: got %b expected 0", pcm_valid); end
    checks++; if (pcm_data !== '0)    begin errors++; $display("FAIL mid_pcm_data: got %0d expected 0", pcm_data); end
    checks++; if (m_clk !== 1'b0)     begin errors++; $display("FAIL mid_m_clk: got %b expected 0", m_clk); end
    checks++; if (overrun !== 1'b0)   begin errors++; $display("FAIL mid_overrun: got %b expected 0", overrun); end
    x.delete();
    rst = 1'b0;
    at  = 0;
    for (int n = 1; n <= PERIOD + 40; n++) begin
      @(posedge clk);
      #1;
      if (pcm_valid) begin at = n; break; end
    end
    checks++;
    if (at != PERIOD + 4) begin
      errors++; $display("FAIL mid_next_sample_time: got %0d expected %0d", at, PERIOD + 4);
    end
    checks++;
    if (at != 0 && int'(pcm_data) != model(1)) begin
      errors++; $display("FAIL mid_next_sample_data: got %0d expected %0d", pcm_data, model(1));
    end
  endtask

  initial begin
    rst       = 1'b1;
    m_data    = 1'b0;
    pcm_ready = 1'b1;
    build_taps();
    test_reset();
    test_const(1'b1);
    test_const(1'b0);
    test_alternate();
    test_stream(3);
    test_stream(4);
    test_overrun();
    test_reset_mid_comb();
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
